uart_tx_mmio: RTL and testbench

- Memory-mapped UART transmitter on the processor data bus, downstream of the single-cycle core.
- Consumes the core's MemWrite, ALUResult (address) and WriteData; returns ReadData for status and config reads.
- Buffers bytes in a small FIFO and serialises them 8N1 on a registered tx line, so firmware can queue console output without stalling the core.

---
 rtl/uart_mmio_pkg.sv | 36 +++
 rtl/uart_tx_mmio_if.sv | 36 +++
 rtl/sync_fifo.sv | 80 ++++++++
 rtl/uart_tx_mmio.sv | 253 +++++++++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_mmio_pkg
// Description : Shared types and constants for the memory-mapped UART
//               transmitter. It holds the transmit FSM state enum, the
//               register offsets (Addr[3:2]) and the STATUS bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_mmio_pkg;

    // PARITY is always part of the encoding. It is only reached when the
    // parity build option is enabled.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Register offsets, expressed as word index Addr[3:2]
    localparam logic [1:0] c_OFF_TXDATA  = 2'd0;
    localparam logic [1:0] c_OFF_STATUS  = 2'd1;
    localparam logic [1:0] c_OFF_BAUDDIV = 2'd2;
    localparam logic [1:0] c_OFF_RSVD    = 2'd3;

    // STATUS register bit positions
    localparam int c_STAT_BUSY    = 0;
    localparam int c_STAT_FULL    = 1;
    localparam int c_STAT_EMPTY   = 2;
    localparam int c_STAT_OVF     = 3;
    localparam int c_STAT_CNT_LSB = 4;
    localparam int c_STAT_PAR     = 8;

endpackage : uart_mmio_pkg
`default_nettype wire

// File: rtl/uart_tx_mmio_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_mmio_if
// Description : Processor data-bus view of the UART transmitter.
//   MemWrite  : store strobe from the core
//   Addr      : byte address (ALUResult)
//   WriteData : store data
//   ReadData  : combinational read data, 0 when the block is not selected
//   Sel       : high when Addr falls inside the block's 16-byte window
//   The master modport is the core side. The slave modport is the peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_mmio_if;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Sel;

    modport master (
        output MemWrite,
        output Addr,
        output WriteData,
        input  ReadData,
        input  Sel
    );

    modport slave (
        input  MemWrite,
        input  Addr,
        input  WriteData,
        output ReadData,
        output Sel
    );
endinterface : uart_tx_mmio_if
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with show-ahead output (dout_o is always
//               the head entry). A push while full is accepted only when a
//               pop happens on the same edge. Pointers wrap modulo DEPTH,
//               so DEPTH must be a power of two.
//   clk      : clock, rising edge
//   reset    : asynchronous reset, active low
//   push_i   : write din_i
//   pop_i    : discard the head entry
//   din_i    : write data
//   dout_o   : head entry
//   full_o   : all DEPTH entries are occupied
//   empty_o  : no entries are occupied
//   count_o  : number of occupied entries
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       din_i,
    output logic [WIDTH-1:0]       dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign w_do_pop  = pop_i && !empty_o;
    // A pop on the same edge frees the slot that a push into a full FIFO needs.
    assign w_do_push = push_i && (!full_o || w_do_pop);

    always_comb begin
        count_d = count_q;
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (w_do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // The storage array has no reset. Only entries that were written are read.
    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_mmio
// Description : Memory-mapped UART transmitter on the core data bus. Bytes
//               written to TXDATA are queued in a small FIFO and sent 8N1
//               (or 8E1) LSB first on a registered tx line.
//   clk    : system clock, rising edge
//   reset  : asynchronous reset, active low
//   bus    : slave side of the core data bus (uart_tx_mmio_if)
//   tx     : serial output, idle high
// Register map (Addr[3:2]):
//   0 TXDATA  : write pushes WriteData[7:0], reads 0
//   1 STATUS  : {23'b0, par_present, count[3:0], ovf, empty, full, busy}.
//               Writing 1 to bit3 clears ovf.
//   2 BAUDDIV : R/W [15:0]. Each bit lasts BAUDDIV+1 clocks.
//   3         : reserved
// Build option: define UART_TX_PARITY_EN to add an even-parity bit after
//               the data bits. STATUS bit8 then reads 1.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_mmio
    import uart_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_tx_mmio_if.slave        bus,
    output logic                 tx
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       w_sel;
    logic [1:0] w_off;
    logic       w_wr;
    logic       w_push;

    assign w_sel  = (bus.Addr[31:4] == BASE_ADDR[31:4]);
    assign w_off  = bus.Addr[3:2];
    assign w_wr   = bus.MemWrite && w_sel;
    assign w_push = w_wr && (w_off == c_OFF_TXDATA);

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    w_head;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_fifo_count;
    logic          w_pop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_txfifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .din_i   (bus.WriteData[7:0]),
        .dout_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_fifo_count)
    );

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    tx_state_e   state_q;
    logic        tx_q;
    logic [15:0] baud_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
`ifdef UART_TX_PARITY_EN
    logic        par_q;
`endif
    logic [15:0] div_q;
    logic [15:0] div_d;
    logic        ovf_q;
    logic        ovf_d;
    logic        w_bit_end;
    logic        w_ovf_set;

    assign w_bit_end = (baud_q == 16'd0);
    // Pop in IDLE, or at the end of STOP so that queued frames follow with no gap.
    assign w_pop     = !w_empty && ((state_q == IDLE) || ((state_q == STOP) && w_bit_end));
    assign w_ovf_set = w_push && w_full && !w_pop;

    always_comb begin
        div_d = div_q;
        if (w_wr && (w_off == c_OFF_BAUDDIV)) div_d = bus.WriteData[15:0];

        ovf_d = ovf_q;
        if (w_wr && (w_off == c_OFF_STATUS) && bus.WriteData[c_STAT_OVF]) ovf_d = 1'b0;
        // A new overflow on the same edge wins over a clear.
        if (w_ovf_set) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= DEFAULT_DIV;
            ovf_q <= 1'b0;
        end else begin
            div_q <= div_d;
            ovf_q <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM with baud counter. tx is registered.
    // The baud counter reloads from the live div_q at every bit start.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (w_pop) begin
                        shift_q <= w_head;
`ifdef UART_TX_PARITY_EN
                        par_q   <= ^w_head;
`endif
                        baud_q  <= div_q;
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                        bit_q   <= 3'd0;
                        baud_q  <= div_q;
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        baud_q <= div_q;
                        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= par_q;
                            state_q <= PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= STOP;
`endif
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                PARITY: begin
                    if (w_bit_end) begin
                        tx_q    <= 1'b1;
                        baud_q  <= div_q;
                        state_q <= STOP;
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        if (w_pop) begin
                            shift_q <= w_head;
`ifdef UART_TX_PARITY_EN
                            par_q   <= ^w_head;
`endif
                            baud_q  <= div_q;
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx = tx_q;

    // ------------------------------------------------------------------
    // Read mux (combinational, single-cycle core)
    // ------------------------------------------------------------------
    logic [7:0]  w_cnt_ext;
    logic [3:0]  w_cnt4;
    logic        w_par_present;
    logic [31:0] w_rdata;

    assign w_cnt_ext = 8'(w_fifo_count);
    assign w_cnt4    = (w_cnt_ext > 8'd15) ? 4'hF : w_cnt_ext[3:0];
`ifdef UART_TX_PARITY_EN
    assign w_par_present = 1'b1;
`else
    assign w_par_present = 1'b0;
`endif

    always_comb begin
        w_rdata = 32'd0;
        if (w_sel) begin
            case (w_off)
                c_OFF_STATUS: begin
                    w_rdata[c_STAT_BUSY]          = (state_q != IDLE);
                    w_rdata[c_STAT_FULL]          = w_full;
                    w_rdata[c_STAT_EMPTY]         = w_empty;
                    w_rdata[c_STAT_OVF]           = ovf_q;
                    w_rdata[c_STAT_CNT_LSB +: 4]  = w_cnt4;
                    w_rdata[c_STAT_PAR]           = w_par_present;
                end
                c_OFF_BAUDDIV: w_rdata[15:0] = div_q;
                default:       w_rdata = 32'd0;
            endcase
        end
    end

    assign bus.ReadData = w_rdata;
    assign bus.Sel      = w_sel;

    // Address byte-lane bits and the upper store data have no use in this block.
    logic w_unused;
    assign w_unused = &{1'b0, bus.Addr[1:0], bus.WriteData[31:16]};

endmodule : uart_tx_mmio
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_mmio
// Description : Self-checking bench for uart_tx_mmio. Randomised byte bursts
//               are compared clock by clock against a frame model built
//               from bit-period arithmetic. The FIFO occupancy is compared
//               against push/pop counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE = 32'h0000_0400;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FB = 10 + PAR;   // bit periods per frame

    logic clk = 1'b0;
    logic reset;
    logic tx;

    uart_tx_mmio_if bus();

    uart_tx_mmio #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (4),
        .DEFAULT_DIV (16'd433)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    logic [7:0] pay [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge. Returns just after the next falling edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.MemWrite  = 1'b1;
        bus.Addr      = a;
        bus.WriteData = d;
        @(posedge clk);
        @(negedge clk);
        bus.MemWrite  = 1'b0;
    endtask

    function automatic logic [31:0] status_word(input int cnt, input bit ovf, input bit busy);
        logic [31:0] w;
        w      = 32'd0;
        w[0]   = busy;
        w[1]   = (cnt == 4);
        w[2]   = (cnt == 0);
        w[3]   = ovf;
        w[7:4] = 4'(cnt);
        w[8]   = (PAR != 0);
        return w;
    endfunction

    // Line level during bit period 'pos' of a frame carrying d
    function automatic logic frame_bit(input logic [7:0] d, input int pos);
        if (pos == 0)                 return 1'b0;
        if (pos <= 8)                 return d[pos-1];
        if ((PAR != 0) && (pos == 9)) return ^d;
        return 1'b1;
    endfunction

    // Sends n bytes from pay[] at BAUDDIV=b on consecutive cycles.
    // Byte 0 is pushed at edge N. k counts samples taken after edge N+1+k.
    task automatic run_frames(input int b, input int n);
        int f;
        f = FB * (b + 1);
        bus_write(BASE + 32'h8, 32'(b));
        for (int i = 0; i < n; i++) bus_write(BASE, {24'd0, pay[i]});
        bus.Addr = BASE + 32'h4;
        for (int k = n - 2; k <= n * f; k++) begin
            if (k >= 0) begin
                int   pushed;
                int   popped;
                logic e;
                #1;
                if (k < n * f) e = frame_bit(pay[k / f], (k % f) / (b + 1));
                else           e = 1'b1;
                pushed = (k + 2 < n) ? k + 2 : n;
                popped = (k / f + 1 < n) ? k / f + 1 : n;
                check($sformatf("tx b=%0d n=%0d k=%0d", b, n, k), 32'(tx), 32'(e));
                check($sformatf("status b=%0d n=%0d k=%0d", b, n, k), bus.ReadData,
                      status_word(pushed - popped, 1'b0, k < n * f));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        bus.MemWrite  = 1'b0;
        bus.Addr      = 32'd0;
        bus.WriteData = 32'd0;
        reset         = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Reset state
        bus.Addr = BASE + 32'h4;
        #1;
        check("rst status", bus.ReadData, status_word(0, 1'b0, 1'b0));
        check("rst tx", 32'(tx), 32'd1);
        check("rst sel", 32'(bus.Sel), 32'd1);
        bus.Addr = BASE + 32'h8;
        #1;
        check("rst bauddiv", bus.ReadData, 32'd433);

        // Decode window
        bus.Addr = BASE + 32'h20;
        #1;
        check("dec sel hi", 32'(bus.Sel), 32'd0);
        check("dec rdata hi", bus.ReadData, 32'd0);
        bus.Addr = BASE - 32'h4;
        #1;
        check("dec sel lo", 32'(bus.Sel), 32'd0);
        @(negedge clk);
        bus_write(BASE + 32'hC, 32'hFFFF_FFFF);
        bus.Addr = BASE + 32'hC;
        #1;
        check("rsvd read", bus.ReadData, 32'd0);
        bus.Addr = BASE + 32'h4;
        #1;
        check("rsvd status", bus.ReadData, status_word(0, 1'b0, 1'b0));
        bus.Addr = BASE + 32'h8;
        #1;
        check("rsvd bauddiv", bus.ReadData, 32'd433);
        bus.Addr = BASE;
        #1;
        check("txdata read", bus.ReadData, 32'd0);
        check("rsvd tx", 32'(tx), 32'd1);
        @(negedge clk);

        // Directed frames
        pay[0] = 8'hA5;
        run_frames(3, 1);
        pay[0] = 8'h01;
        pay[1] = 8'h02;
        run_frames(1, 2);
        pay[0] = 8'h07;
        run_frames(0, 1);

        // Randomised bursts
        for (int t = 0; t < 8; t++) begin
            int b;
            int n;
            b = $urandom_range(0, 4);
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
            run_frames(b, n);
        end

        // Overflow: byte 1 pops at once, bytes 2-5 fill the FIFO, byte 6 drops
        bus_write(BASE + 32'h8, 32'd100);
        for (int i = 0; i < 6; i++) bus_write(BASE, 32'h30 + 32'(i));
        bus.Addr = BASE + 32'h4;
        #1;
        check("ovf status", bus.ReadData, status_word(4, 1'b1, 1'b1));
        check("ovf tx start", 32'(tx), 32'd0);
        @(negedge clk);
        bus_write(BASE + 32'h4, 32'h8);
        bus.Addr = BASE + 32'h4;
        #1;
        check("ovf clear", bus.ReadData, status_word(4, 1'b0, 1'b1));
        check("mid-frame tx", 32'(tx), 32'd0);

        // Asynchronous reset in the middle of a frame
        reset = 1'b0;
        #1;
        check("async rst tx", 32'(tx), 32'd1);
        check("async rst status", bus.ReadData, status_word(0, 1'b0, 1'b0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        bus.Addr = BASE + 32'h8;
        #1;
        check("async rst bauddiv", bus.ReadData, 32'd433);
        check("post rst tx", 32'(tx), 32'd1);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_uart_tx_mmio
`default_nettype wire
